rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Power-on and recovery sequencer for the board PLL and the downstream reset domains. It runs from the free-running board clock, never from a PLL output. It drives the PLL reset, waits for a stable lock with timeout and retry, then releases N reset domains in a fixed order with programmable gaps. On lock loss it re-enters reset and reports the event. It sits at the top of the clock/reset tree and feeds the per-domain reset synchronisers.

Parameters:
N_DOM, 3, number of sequenced reset domains; domain 0 is released first.
PLL_RST_CYC, 16, cycles pll_reset is held high per PLL reset attempt.
LOCK_STABLE_CYC, 256, consecutive synchronised-locked cycles required before release.
LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK before a retry.
REL_GAP, 8, cycles between successive domain releases.
MAX_RETRY, 3, number of timed-out lock attempts before FAIL.
CNT_W, 16, width of the shared cycle counter; must hold max(all cycle parameters).

Ports:
clk_in  input  1  free-running board clock
RSTn  input  1  asynchronous active-low reset
pll_locked  input  1  PLL lock status, asynchronous to clk_in
sw_rst_req  input  1  soft reset request, level, clk_in domain
pll_reset  output  1  active-high PLL reset
dom_rst_n  output  N_DOM  per-domain active-low reset
init_done  output  1  high while in RUN
lock_lost  output  1  sticky: lock dropped after STABLE was reached
lock_fail  output  1  high in FAIL
state_o  output  3  current state encoding, for debug

Behaviour:
- Reset (RSTn=0): state=PLL_RST, cnt=0, retry=0.
- Output reset values: pll_reset=1, dom_rst_n=0, init_done=0, lock_lost=0, lock_fail=0.
- All outputs are registered.
- pll_locked passes through a 2-FF synchroniser (lk_s), adding 2 cycles of latency. Its flops reset to 0.
- States and encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.
- cnt clears on every state entry.
- PLL_RST:
  - pll_reset=1 for exactly PLL_RST_CYC cycles.
  - Then go to WAIT_LOCK, with pll_reset=0.
- WAIT_LOCK:
  - lk_s=1 -> STABLE.
  - cnt reaches LOCK_TIMEOUT-1 -> retry+1.
  - After that increment, retry==MAX_RETRY -> FAIL; otherwise -> PLL_RST.
- STABLE:
  - lk_s=0 -> cnt=0, stay in STABLE. This is a glitch filter, not a lock loss.
  - cnt reaches LOCK_STABLE_CYC-1 with lk_s=1 -> RELEASE.
- RELEASE:
  - dom_rst_n[k] goes high at cycle REL_GAP*(k+1)-1 after entry.
  - Released bits stay high.
  - The cycle after dom_rst_n[N_DOM-1] rises -> RUN, with init_done=1 and retry=0.
- RUN:
  - Hold all outputs.
  - sw_rst_req=1 -> next cycle dom_rst_n=0 and init_done=0, then go to RELEASE. The PLL is not reset.
- Lock loss:
  - Condition: lk_s=0 while in RELEASE or RUN.
  - Next cycle: dom_rst_n all 0, init_done=0, lock_lost=1, go to PLL_RST.
  - lock_lost clears only on RSTn.
- FAIL:
  - pll_reset=1, dom_rst_n=0, lock_fail=1.
  - Exit only via RSTn.
- Simultaneous lock loss and sw_rst_req in RUN: lock loss wins.
- sw_rst_req is ignored outside RUN.
- RSTn asserted mid-sequence: immediate asynchronous return to the reset values above. This includes clearing lock_lost and retry.
- Domain resets are never deasserted out of order. No dom_rst_n bit is high unless all lower-index bits are high.

Test Plan:
1. Nominal bring-up: RSTn released, pll_locked=1 from cycle 40.
   - pll_reset high for cycles 0..15.
   - dom_rst_n goes 001, 011, 111 at 8-cycle spacing.
   - init_done=1 one cycle after bit 2 rises.
2. Lock glitch in STABLE: drop pll_locked for 1 cycle at STABLE cnt=200.
   - cnt restarts.
   - Release is delayed by exactly the glitch offset plus synchroniser cycles.
   - lock_lost stays 0.
3. Timeout/retry (test parameters LOCK_TIMEOUT=100, MAX_RETRY=3): pll_locked held 0.
   - Three PLL_RST pulses of 16 cycles each.
   - Then FAIL, with lock_fail=1 and pll_reset=1 held.
   - Only RSTn recovers.
4. Lock loss in RUN: pll_locked falls.
   - dom_rst_n=000 within 3 cycles (2 synchroniser + 1).
   - lock_lost=1, state_o=0.
   - Re-lock yields a full re-sequence with lock_lost still 1.
5. Soft reset: 1-cycle sw_rst_req in RUN.
   - dom_rst_n=000 next cycle; pll_reset stays 0.
   - Domains re-released at 8/16/24 cycles.
   - Same cycle as lock loss -> PLL_RST path taken.
6. RSTn pulse mid-RELEASE (after dom_rst_n=011): all outputs return to reset values asynchronously, and the sequence restarts from PLL_RST.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// PLL reset and lock-qualification sequencer that releases N_DOM reset domains in order.
// Runs from the free-running board clock. Every output is registered.
module rst_seq_ctrl #(
    parameter int unsigned N_DOM           = 3,
    parameter int unsigned PLL_RST_CYC     = 16,
    parameter int unsigned LOCK_STABLE_CYC = 256,
    parameter int unsigned LOCK_TIMEOUT    = 65535,
    parameter int unsigned REL_GAP         = 8,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk_in,
    input  logic             RSTn,
    input  logic             pll_locked,
    input  logic             sw_rst_req,
    output logic             pll_reset,
    output logic [N_DOM-1:0] dom_rst_n,
    output logic             init_done,
    output logic             lock_lost,
    output logic             lock_fail,
    output logic [2:0]       state_o
);
    localparam int unsigned      RW        = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_GAP * N_DOM - 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_e;

    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d, retry_inc;
    logic [1:0]       sync_q;
    logic             lk_s;
    logic             pll_reset_q, pll_reset_d;
    logic [N_DOM-1:0] dom_q, dom_d;
    logic             init_q, init_d;
    logic             lost_q, lost_d;
    logic             fail_q, fail_d;
    logic             lock_drop;

    assign lk_s = sync_q[1];

    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q + 1'b1;
        retry_d     = retry_q;
        retry_inc   = retry_q + 1'b1;
        pll_reset_d = pll_reset_q;
        dom_d       = dom_q;
        init_d      = init_q;
        lost_d      = lost_q;
        fail_d      = fail_q;
        lock_drop   = 1'b0;

        case (st_q)
            PLL_RST: begin
                if (cnt_q == PLL_LAST) begin
                    st_d        = WAIT_LOCK;
                    cnt_d       = '0;
                    pll_reset_d = 1'b0;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    st_d  = STABLE;
                    cnt_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    retry_d     = retry_inc;
                    cnt_d       = '0;
                    pll_reset_d = 1'b1;
                    if (retry_inc == RETRY_MAX) begin
                        st_d   = FAIL;
                        fail_d = 1'b1;
                    end else begin
                        st_d = PLL_RST;
                    end
                end
            end
            STABLE: begin
                // A dropout only restarts the qualification window; it is not a lock loss.
                if (!lk_s) begin
                    cnt_d = '0;
                end else if (cnt_q == STB_LAST) begin
                    st_d  = RELEASE;
                    cnt_d = '0;
                    dom_d = '0;
                end
            end
            RELEASE: begin
                if (!lk_s) begin
                    lock_drop = 1'b1;
                end else if (cnt_q == REL_LAST) begin
                    st_d    = RUN;
                    cnt_d   = '0;
                    init_d  = 1'b1;
                    retry_d = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lk_s) begin
                    lock_drop = 1'b1;
                end else if (sw_rst_req) begin
                    st_d   = RELEASE;
                    dom_d  = '0;
                    init_d = 1'b0;
                end
            end
            default: begin
                st_d        = FAIL;
                cnt_d       = '0;
                pll_reset_d = 1'b1;
                dom_d       = '0;
                init_d      = 1'b0;
                fail_d      = 1'b1;
            end
        endcase

        if (lock_drop) begin
            st_d        = PLL_RST;
            cnt_d       = '0;
            pll_reset_d = 1'b1;
            dom_d       = '0;
            init_d      = 1'b0;
            lost_d      = 1'b1;
        end

        // Bits are set from the next count so each rises in the cycle where cnt equals its slot.
        if (st_d == RELEASE) begin
            for (int unsigned k = 0; k < N_DOM; k++) begin
                if (cnt_d == CNT_W'(REL_GAP * (k + 1) - 1)) dom_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge RSTn) begin
        if (!RSTn) begin
            st_q        <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_reset_q <= 1'b1;
            dom_q       <= '0;
            init_q      <= 1'b0;
            lost_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync_q      <= {sync_q[0], pll_locked};
            pll_reset_q <= pll_reset_d;
            dom_q       <= dom_d;
            init_q      <= init_d;
            lost_q      <= lost_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign dom_rst_n = dom_q;
    assign init_done = init_q;
    assign lock_lost = lost_q;
    assign lock_fail = fail_q;
    assign state_o   = st_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: phase/age reference model checked every cycle, plus directed
// timeline checks with hand-computed cycle numbers and a randomized soak.
module tb_rst_seq_ctrl;
    localparam int unsigned N_DOM           = 3;
    localparam int unsigned PLL_RST_CYC     = 16;
    localparam int unsigned LOCK_STABLE_CYC = 256;
    localparam int unsigned LOCK_TIMEOUT    = 100;
    localparam int unsigned REL_GAP         = 8;
    localparam int unsigned MAX_RETRY       = 3;
    localparam int unsigned CNT_W           = 16;

    localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_REL = 3, P_RUN = 4, P_FAIL = 5;

    logic             clk_in     = 1'b0;
    logic             RSTn       = 1'b1;
    logic             pll_locked = 1'b0;
    logic             sw_rst_req = 1'b0;
    logic             pll_reset;
    logic [N_DOM-1:0] dom_rst_n;
    logic             init_done;
    logic             lock_lost;
    logic             lock_fail;
    logic [2:0]       state_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit armed  = 1'b0;
    int ec     = 0;

    rst_seq_ctrl #(
        .N_DOM          (N_DOM),
        .PLL_RST_CYC    (PLL_RST_CYC),
        .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .REL_GAP        (REL_GAP),
        .MAX_RETRY      (MAX_RETRY),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_in    (clk_in),
        .RSTn      (RSTn),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .pll_reset (pll_reset),
        .dom_rst_n (dom_rst_n),
        .init_done (init_done),
        .lock_lost (lock_lost),
        .lock_fail (lock_fail),
        .state_o   (state_o)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: phase, cycles spent in it, retry count, sticky loss, 2-deep lock history.
    int m_ph, m_age, m_retry;
    bit m_lost, m_s1, m_s2;

    task automatic m_reset();
        m_ph = P_RST; m_age = 0; m_retry = 0; m_lost = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic m_enter(input int ph);
        m_ph = ph; m_age = 0;
    endtask

    task automatic m_step(input bit lk_in, input bit sw);
        bit lk;
        lk = m_s2; m_s2 = m_s1; m_s1 = lk_in;
        case (m_ph)
            P_RST:  if (m_age == int'(PLL_RST_CYC) - 1) m_enter(P_WAIT); else m_age++;
            P_WAIT: begin
                if (lk) m_enter(P_STB);
                else if (m_age == int'(LOCK_TIMEOUT) - 1) begin
                    m_retry++;
                    m_enter((m_retry == int'(MAX_RETRY)) ? P_FAIL : P_RST);
                end else m_age++;
            end
            P_STB:  if (!lk) m_age = 0; else if (m_age == int'(LOCK_STABLE_CYC) - 1) m_enter(P_REL); else m_age++;
            P_REL, P_RUN: begin
                if (!lk) begin m_lost = 1'b1; m_enter(P_RST); end
                else if (m_ph == P_REL && m_age == int'(REL_GAP * N_DOM) - 1) begin m_retry = 0; m_enter(P_RUN); end
                else if (m_ph == P_RUN && sw) m_enter(P_REL);
                else m_age++;
            end
            default: ;
        endcase
    endtask

    function automatic logic [N_DOM-1:0] m_dom();
        logic [N_DOM-1:0] d;
        for (int k = 0; k < int'(N_DOM); k++)
            d[k] = (m_ph == P_RUN) || (m_ph == P_REL && m_age >= int'(REL_GAP) * (k + 1) - 1);
        return d;
    endfunction

    logic             e_pr, e_init, e_lost, e_fail;
    logic [N_DOM-1:0] e_dom;
    logic [2:0]       e_st;

    always begin
        @(posedge clk_in);
        if (!RSTn) m_reset(); else m_step(pll_locked, sw_rst_req);
        #1;
        if (armed) begin
            e_pr = (m_ph == P_RST || m_ph == P_FAIL); e_dom = m_dom(); e_init = (m_ph == P_RUN);
            e_lost = m_lost; e_fail = (m_ph == P_FAIL); e_st = 3'(m_ph);
            n_chk++;
            if (pll_reset !== e_pr || dom_rst_n !== e_dom || init_done !== e_init ||
                lock_lost !== e_lost || lock_fail !== e_fail || state_o !== e_st) begin
                n_fail++;
                $display("FAIL model t=%0t: got pr=%b dom=%b init=%b lost=%b fail=%b st=%0d, expected pr=%b dom=%b init=%b lost=%b fail=%b st=%0d",
                         $time, pll_reset, dom_rst_n, init_done, lock_lost, lock_fail, state_o,
                         e_pr, e_dom, e_init, e_lost, e_fail, e_st);
            end
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, ec, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in); #1; ec++;
    endtask

    task automatic to(input int n);
        while (ec < n) cyc();
    endtask

    // Called 1 time unit after an edge; asserts RSTn away from the sampling point.
    task automatic do_reset();
        #2 RSTn = 1'b0; armed = 1'b1;
        #1;
        chk("async_pll_reset", 32'(pll_reset), 1);
        chk("async_dom",       32'(dom_rst_n), 0);
        chk("async_init",      32'(init_done), 0);
        chk("async_lost",      32'(lock_lost), 0);
        chk("async_fail",      32'(lock_fail), 0);
        chk("async_state",     32'(state_o),   0);
        repeat (3) cyc();
        #2 RSTn = 1'b1;
        ec = 0;
    endtask

    initial begin
        cyc();
        // Nominal bring-up, lock from cycle 40
        pll_locked = 1'b0; do_reset();
        to(15);  chk("t1_pll_hi",  32'(pll_reset), 1); chk("t1_st_rst", 32'(state_o), 0);
        to(16);  chk("t1_pll_lo",  32'(pll_reset), 0); chk("t1_st_wait", 32'(state_o), 1);
        to(39);  pll_locked = 1'b1;
        to(297); chk("t1_st_stb",  32'(state_o), 2);
        to(298); chk("t1_st_rel",  32'(state_o), 3); chk("t1_dom0", 32'(dom_rst_n), 0);
        to(304); chk("t1_dom_pre", 32'(dom_rst_n), 0);
        to(305); chk("t1_dom001",  32'(dom_rst_n), 1);
        to(313); chk("t1_dom011",  32'(dom_rst_n), 3);
        to(321); chk("t1_dom111",  32'(dom_rst_n), 7); chk("t1_init_pre", 32'(init_done), 0);
        to(322); chk("t1_init",    32'(init_done), 1); chk("t1_st_run", 32'(state_o), 4);
        // Lock loss in RUN, then full re-sequence
        to(330); pll_locked = 1'b0;
        to(332); chk("t4_dom_hold", 32'(dom_rst_n), 7);
        to(333); chk("t4_dom0", 32'(dom_rst_n), 0); chk("t4_lost", 32'(lock_lost), 1);
                 chk("t4_st", 32'(state_o), 0); chk("t4_init", 32'(init_done), 0);
        to(340); pll_locked = 1'b1;
        to(349); chk("t4_st_wait", 32'(state_o), 1);
        to(350); chk("t4_st_stb",  32'(state_o), 2);
        to(629); chk("t4_st_rel",  32'(state_o), 3);
        to(630); chk("t4_run", 32'(state_o), 4); chk("t4_init1", 32'(init_done), 1);
                 chk("t4_lost_sticky", 32'(lock_lost), 1);
        // One-cycle soft reset in RUN
        to(640); sw_rst_req = 1'b1;
        to(641); sw_rst_req = 1'b0;
                 chk("t5_dom0", 32'(dom_rst_n), 0); chk("t5_init0", 32'(init_done), 0);
                 chk("t5_st_rel", 32'(state_o), 3); chk("t5_pll_lo", 32'(pll_reset), 0);
        to(647); chk("t5_dom_pre", 32'(dom_rst_n), 0);
        to(648); chk("t5_dom001", 32'(dom_rst_n), 1);
        to(656); chk("t5_dom011", 32'(dom_rst_n), 3);
        to(664); chk("t5_dom111", 32'(dom_rst_n), 7);
        to(665); chk("t5_run", 32'(state_o), 4);
        // Soft reset coinciding with lock loss: PLL path wins
        to(680); pll_locked = 1'b0;
        to(682); sw_rst_req = 1'b1;
        to(683); sw_rst_req = 1'b0;
                 chk("t5_both_st", 32'(state_o), 0); chk("t5_both_pll", 32'(pll_reset), 1);
        // RSTn pulse mid-RELEASE
        to(690); pll_locked = 1'b1;
        to(699); chk("t6_st_wait", 32'(state_o), 1);
        to(700); chk("t6_st_stb",  32'(state_o), 2);
        to(956); chk("t6_st_rel",  32'(state_o), 3);
        to(973); chk("t6_dom011",  32'(dom_rst_n), 3); chk("t6_lost", 32'(lock_lost), 1);
        do_reset();
        to(16);  chk("t6_restart_wait", 32'(state_o), 1);
        to(17);  chk("t6_restart_stb",  32'(state_o), 2);
        // Single-cycle glitch at STABLE cnt=200
        pll_locked = 1'b1; do_reset();
        to(17);  chk("t2_st_stb", 32'(state_o), 2);
        to(217); pll_locked = 1'b0;
        to(218); pll_locked = 1'b1;
        to(475); chk("t2_still_stb", 32'(state_o), 2);
        to(476); chk("t2_rel", 32'(state_o), 3); chk("t2_lost", 32'(lock_lost), 0);
        // Timeout and retry into FAIL
        pll_locked = 1'b0; do_reset();
        to(115); chk("t3_wait1",  32'(state_o), 1);
        to(116); chk("t3_rst2",   32'(state_o), 0); chk("t3_pll2", 32'(pll_reset), 1);
        to(131); chk("t3_rst2_end", 32'(state_o), 0);
        to(132); chk("t3_wait2",  32'(state_o), 1);
        to(232); chk("t3_rst3",   32'(state_o), 0);
        to(248); chk("t3_wait3",  32'(state_o), 1);
        to(347); chk("t3_wait3_end", 32'(state_o), 1); chk("t3_nofail", 32'(lock_fail), 0);
        to(348); chk("t3_fail", 32'(state_o), 5); chk("t3_lock_fail", 32'(lock_fail), 1);
                 chk("t3_pll_fail", 32'(pll_reset), 1);
        pll_locked = 1'b1;
        to(400); chk("t3_fail_hold", 32'(state_o), 5); chk("t3_dom_fail", 32'(dom_rst_n), 0);
        // Randomized soak against the model
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            cyc();
            if (pll_locked && $urandom_range(0, 999) < 3) pll_locked = 1'b0;
            else if (!pll_locked && $urandom_range(0, 99) < 15) pll_locked = 1'b1;
            sw_rst_req = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 2499) == 0) do_reset();
        end
        sw_rst_req = 1'b0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
